nlp_update_arbiter: RTL and testbench
=====================================

Name: nlp_update_arbiter

Overview:
Sequences all writes into the next-line-predictor (NLP) table, which has a single write port. Update requests come from IF3 (early fetch-stage corrections) and the backend (resolved branches); each source gets its own small queue. Queued updates are arbitrated onto the table write port with backend priority and bounded IF3 starvation. After reset it also runs an invalidate sweep over every table entry before normal operation.

Parameters:
IDX_W, 6, NLP table index width; table holds 2^IDX_W entries
TAG_W, 8, tag width stored per entry
Q_DEPTH, 4, entries per source queue (power of two, >=2)
STARVE_MAX, 4, consecutive backend grants after which a pending IF3 entry is forced through

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
if3_upd_valid  in  1  IF3 update request
if3_upd_ready  out  1  IF3 queue can accept
if3_upd_pc  in  32  branch PC
if3_upd_target  in  32  predicted next-line target
if3_upd_taken  in  1  taken bit to store
be_upd_valid  in  1  backend update request
be_upd_ready  out  1  backend queue can accept
be_upd_pc  in  32  branch PC
be_upd_target  in  32  resolved target
be_upd_taken  in  1  resolved taken bit
flush  in  1  backend redirect; discards IF3 queue contents
tbl_we  out  1  table write enable
tbl_idx  out  IDX_W  write index = pc[IDX_W+1:2]
tbl_tag  out  TAG_W  tag = pc[IDX_W+TAG_W+1:IDX_W+2]
tbl_target  out  32  target to store
tbl_taken  out  1  taken bit to store
tbl_valid  out  1  entry valid bit to store
init_done  out  1  high once invalidate sweep finished

Behaviour:
- Reset (async): FSM=INIT, sweep counter=0, both queues empty, starve counter=0, all outputs 0.
- INIT: tbl_we=1, tbl_idx=counter, tbl_valid=0, tag/target/taken=0; counter++ each cycle; after writing index 2^IDX_W-1 go to RUN. Sweep takes exactly 2^IDX_W cycles. Both readies 0 in INIT.
- RUN: init_done=1. x_upd_ready = (queue count < Q_DEPTH), from registered count only; a full queue stays not-ready even if popped that cycle.
- Enqueue on valid&&ready at edge; earliest table write from that entry is the following cycle (1-cycle latency). No same-cycle bypass.
- Arbitration each RUN cycle, one write max: if backend queue nonempty and not (IF3 nonempty and starve==STARVE_MAX) -> pop backend, starve++ if IF3 nonempty (saturates at STARVE_MAX); else if IF3 nonempty -> pop IF3, starve=0. Backend-only grants with IF3 empty hold starve at 0.
- Write outputs: tbl_we=1, tbl_valid=1, fields from popped entry. tbl_* are registered outputs of the cycle's grant (write visible at table one cycle after pop decision); tbl_we=0 when nothing popped.
- flush: at edge, IF3 queue cleared and starve=0; an IF3 enqueue in the same cycle is discarded; an IF3 pop decided in the same cycle still writes (already committed). Backend queue unaffected.
- Queue pointers are log2(Q_DEPTH) bits, wrap naturally; count is log2(Q_DEPTH)+1 bits.
- Simultaneous enqueue and pop on same queue: count unchanged.
- Reset asserted mid-sweep or mid-RUN: immediately returns to INIT, queues lost, sweep restarts at 0.

Optional Feature:
NLP_UPD_MERGE_EN: when defined, an incoming backend update whose tbl_idx equals the backend queue tail entry's index (queue nonempty, tail not being popped this cycle) overwrites that tail entry instead of enqueueing; be_upd_ready is then 1 even when full if merge applies. Without the macro every accepted update occupies a new entry.

Test Plan:
- IDX_W=4, release reset -> tbl_we=1, tbl_valid=0 for 16 consecutive cycles idx 0..15, then init_done=1, readies=1.
- One backend update pc=0x8000_0010 target=0x8000_0100 taken=1 -> next cycle tbl_we=1, tbl_idx=4, tbl_valid=1, target 0x8000_0100.
- IF3 and backend valid same cycle -> backend written first, IF3 one cycle later.
- Backend stream continuous with one IF3 entry pending, STARVE_MAX=4 -> 4 backend writes, then IF3 write, then backend resumes.
- 3 IF3 entries queued, flush pulse -> no further IF3 writes; if3_upd_ready stays 1.
- Q_DEPTH=4, 4 backend enqueues with table grants blocked only by stimulus order -> be_upd_ready=0 while count=4; with NLP_UPD_MERGE_EN, same-index 5th update accepted and written target equals 5th value.

Source files
------------

// File: rtl/nlp_update_arbiter.sv
// nlp_update_arbiter
// Sequences every write into the single-write-port next-line-predictor table.
// After reset it sweeps all 2^IDX_W entries to invalid. It then arbitrates two
// update queues (IF3 early corrections, backend resolved branches) onto the
// write port. The backend has priority. IF3 is forced through after STARVE_MAX
// consecutive backend grants while it waits.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   if3_upd_*                     IF3 update request (valid/ready, pc, target, taken)
//   be_upd_*                      backend update request (valid/ready, pc, target, taken)
//   flush                         backend redirect; drops IF3 queue contents
//   tbl_we/idx/tag/target/taken/valid   registered table write port
//   init_done                     high once the invalidate sweep has finished
//
// Optional build macro
//   NLP_UPD_MERGE_EN  a backend update hitting the backend queue tail's index
//                     overwrites that tail instead of taking a new entry
module nlp_update_arbiter #(
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned TAG_W      = 8,
    parameter int unsigned Q_DEPTH    = 4,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if3_upd_valid,
    output logic             if3_upd_ready,
    input  logic [31:0]      if3_upd_pc,
    input  logic [31:0]      if3_upd_target,
    input  logic             if3_upd_taken,
    input  logic             be_upd_valid,
    output logic             be_upd_ready,
    input  logic [31:0]      be_upd_pc,
    input  logic [31:0]      be_upd_target,
    input  logic             be_upd_taken,
    input  logic             flush,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_idx,
    output logic [TAG_W-1:0] tbl_tag,
    output logic [31:0]      tbl_target,
    output logic             tbl_taken,
    output logic             tbl_valid,
    output logic             init_done
);

    localparam int unsigned PTR_W = $clog2(Q_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic             taken;
    } upd_t;

    upd_t if3_q [Q_DEPTH];
    upd_t be_q  [Q_DEPTH];

    logic [0:0]       state, state_nxt;
    logic [IDX_W-1:0] sweep, sweep_nxt;
    logic [PTR_W-1:0] if3_rd, if3_rd_nxt, if3_wr, if3_wr_nxt;
    logic [PTR_W-1:0] be_rd, be_rd_nxt, be_wr, be_wr_nxt;
    logic [CNT_W-1:0] if3_cnt, if3_cnt_nxt, be_cnt, be_cnt_nxt;
    logic [STV_W-1:0] starve, starve_nxt, starve_grant;
    logic             if3_ready_q, be_ready_q, if3_rdy_nxt, be_rdy_nxt;

    logic             we_nxt, taken_nxt, valid_nxt, done_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [TAG_W-1:0] tag_nxt;
    logic [31:0]      target_nxt;

    logic             if3_nonempty, be_nonempty, starve_at_max;
    logic             if3_pop_c, be_pop_c, if3_push_c, be_push_c, merge_hit_c;
    upd_t             if3_in, be_in, grant;
    logic             unused_pc_bits;

    // Table index/tag are fixed slices of the branch PC
    assign if3_in = '{idx:    if3_upd_pc[IDX_W+1:2],
                      tag:    if3_upd_pc[IDX_W+TAG_W+1:IDX_W+2],
                      target: if3_upd_target,
                      taken:  if3_upd_taken};
    assign be_in  = '{idx:    be_upd_pc[IDX_W+1:2],
                      tag:    be_upd_pc[IDX_W+TAG_W+1:IDX_W+2],
                      target: be_upd_target,
                      taken:  be_upd_taken};

    assign unused_pc_bits = ^{if3_upd_pc[1:0], if3_upd_pc[31:IDX_W+TAG_W+2],
                              be_upd_pc[1:0],  be_upd_pc[31:IDX_W+TAG_W+2]};

    assign if3_nonempty  = (if3_cnt != '0);
    assign be_nonempty   = (be_cnt != '0);
    assign starve_at_max = (starve == STV_W'(STARVE_MAX));

    // Arbitration: depends on registered queue state only
    always_comb begin : arb
        be_pop_c     = 1'b0;
        if3_pop_c    = 1'b0;
        starve_grant = starve;
        if (state == ST_RUN) begin
            if (be_nonempty && !(if3_nonempty && starve_at_max)) begin
                be_pop_c = 1'b1;
                if (!if3_nonempty) begin
                    starve_grant = '0;
                end else if (!starve_at_max) begin
                    starve_grant = starve + STV_W'(1);
                end
            end else if (if3_nonempty) begin
                if3_pop_c    = 1'b1;
                starve_grant = '0;
            end
        end
    end

    assign grant = be_pop_c ? be_q[be_rd] : if3_q[if3_rd];

`ifdef NLP_UPD_MERGE_EN
    logic [PTR_W-1:0] be_tail;
    logic             be_merge_c;

    // Tail is mergeable unless it is the sole entry and leaves this cycle
    assign be_tail     = be_wr - PTR_W'(1);
    assign merge_hit_c = (state == ST_RUN) && be_nonempty &&
                         !(be_pop_c && (be_cnt == CNT_W'(1))) &&
                         (be_q[be_tail].idx == be_in.idx);
    assign be_merge_c  = be_upd_valid && merge_hit_c;
    assign be_upd_ready = be_ready_q || merge_hit_c;
`else
    assign merge_hit_c  = 1'b0;
    assign be_upd_ready = be_ready_q;
`endif

    assign if3_upd_ready = if3_ready_q;

    // A flush in the same cycle discards the incoming IF3 update
    assign if3_push_c = if3_upd_valid && if3_ready_q && !flush;
    assign be_push_c  = be_upd_valid && be_ready_q && !merge_hit_c;

    // Next-state and registered-output values
    always_comb begin : next_state
        state_nxt   = state;
        sweep_nxt   = sweep;
        we_nxt      = 1'b0;
        idx_nxt     = '0;
        tag_nxt     = '0;
        target_nxt  = '0;
        taken_nxt   = 1'b0;
        valid_nxt   = 1'b0;

        case (state)
            ST_INIT: begin
                we_nxt    = 1'b1;
                idx_nxt   = sweep;
                sweep_nxt = sweep + IDX_W'(1);
                if (sweep == '1) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (be_pop_c || if3_pop_c) begin
                    we_nxt     = 1'b1;
                    valid_nxt  = 1'b1;
                    idx_nxt    = grant.idx;
                    tag_nxt    = grant.tag;
                    target_nxt = grant.target;
                    taken_nxt  = grant.taken;
                end
            end
            default: state_nxt = ST_INIT;
        endcase

        if3_rd_nxt  = if3_rd + PTR_W'(if3_pop_c);
        if3_wr_nxt  = if3_wr + PTR_W'(if3_push_c);
        if3_cnt_nxt = if3_cnt + CNT_W'(if3_push_c) - CNT_W'(if3_pop_c);
        be_rd_nxt   = be_rd + PTR_W'(be_pop_c);
        be_wr_nxt   = be_wr + PTR_W'(be_push_c);
        be_cnt_nxt  = be_cnt + CNT_W'(be_push_c) - CNT_W'(be_pop_c);
        starve_nxt  = starve_grant;

        if (flush) begin
            if3_rd_nxt  = '0;
            if3_wr_nxt  = '0;
            if3_cnt_nxt = '0;
            starve_nxt  = '0;
        end

        // Ready reflects the count that will be registered
        done_nxt    = (state_nxt == ST_RUN);
        if3_rdy_nxt = (state_nxt == ST_RUN) && (if3_cnt_nxt < CNT_W'(Q_DEPTH));
        be_rdy_nxt  = (state_nxt == ST_RUN) && (be_cnt_nxt < CNT_W'(Q_DEPTH));
    end

    // Control state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INIT;
            sweep       <= '0;
            if3_rd      <= '0;
            if3_wr      <= '0;
            if3_cnt     <= '0;
            be_rd       <= '0;
            be_wr       <= '0;
            be_cnt      <= '0;
            starve      <= '0;
            if3_ready_q <= 1'b0;
            be_ready_q  <= 1'b0;
            tbl_we      <= 1'b0;
            tbl_idx     <= '0;
            tbl_tag     <= '0;
            tbl_target  <= '0;
            tbl_taken   <= 1'b0;
            tbl_valid   <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            state       <= state_nxt;
            sweep       <= sweep_nxt;
            if3_rd      <= if3_rd_nxt;
            if3_wr      <= if3_wr_nxt;
            if3_cnt     <= if3_cnt_nxt;
            be_rd       <= be_rd_nxt;
            be_wr       <= be_wr_nxt;
            be_cnt      <= be_cnt_nxt;
            starve      <= starve_nxt;
            if3_ready_q <= if3_rdy_nxt;
            be_ready_q  <= be_rdy_nxt;
            tbl_we      <= we_nxt;
            tbl_idx     <= idx_nxt;
            tbl_tag     <= tag_nxt;
            tbl_target  <= target_nxt;
            tbl_taken   <= taken_nxt;
            tbl_valid   <= valid_nxt;
            init_done   <= done_nxt;
        end
    end

    // Queue storage; contents are meaningful only between rd and wr pointers
    always_ff @(posedge clk) begin
        if (if3_push_c) begin
            if3_q[if3_wr] <= if3_in;
        end
        if (be_push_c) begin
            be_q[be_wr] <= be_in;
        end
`ifdef NLP_UPD_MERGE_EN
        else if (be_merge_c) begin
            be_q[be_tail] <= be_in;
        end
`endif
    end

endmodule

// File: tb/tb_nlp_update_arbiter.sv
// Testbench for nlp_update_arbiter: a queue-based reference model predicts
// every table write and ready/init_done value; a monitor compares the table
// write port against the expected-write queue.
module tb_nlp_update_arbiter;

    localparam int unsigned IDX_W = 4;
    localparam int unsigned TAG_W = 8;
    localparam int unsigned QD    = 4;
    localparam int unsigned SM    = 4;
    localparam int unsigned NENT  = 1 << IDX_W;

    logic             clk;
    logic             rst;
    logic             if3_upd_valid, if3_upd_ready, if3_upd_taken;
    logic [31:0]      if3_upd_pc, if3_upd_target;
    logic             be_upd_valid, be_upd_ready, be_upd_taken;
    logic [31:0]      be_upd_pc, be_upd_target;
    logic             flush;
    logic             tbl_we, tbl_taken, tbl_valid, init_done;
    logic [IDX_W-1:0] tbl_idx;
    logic [TAG_W-1:0] tbl_tag;
    logic [31:0]      tbl_target;

    nlp_update_arbiter #(
        .IDX_W(IDX_W), .TAG_W(TAG_W), .Q_DEPTH(QD), .STARVE_MAX(SM)
    ) dut (
        .clk(clk), .rst(rst),
        .if3_upd_valid(if3_upd_valid), .if3_upd_ready(if3_upd_ready),
        .if3_upd_pc(if3_upd_pc), .if3_upd_target(if3_upd_target),
        .if3_upd_taken(if3_upd_taken),
        .be_upd_valid(be_upd_valid), .be_upd_ready(be_upd_ready),
        .be_upd_pc(be_upd_pc), .be_upd_target(be_upd_target),
        .be_upd_taken(be_upd_taken),
        .flush(flush),
        .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_tag(tbl_tag),
        .tbl_target(tbl_target), .tbl_taken(tbl_taken), .tbl_valid(tbl_valid),
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } m_ent_t;

    // Reference model state
    m_ent_t      mif3[$];
    m_ent_t      mbe[$];
    int          mstarve;
    bit          mrun;
    int          msweep;

    // Expected writes: {2'b0, cycle[15:0], idx, tag, target, taken, valid}
    logic [63:0] expq[$];
    int          cyc;
    bit          mon_en;
    int          n_chk;
    int          n_fail;

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
        return pc[IDX_W+TAG_W+1:IDX_W+2];
    endfunction

    function automatic logic [63:0] pack_wr(input int c, input logic [IDX_W-1:0] idx,
                                            input logic [TAG_W-1:0] tag, input logic [31:0] tgt,
                                            input logic tk, input logic vld);
        return {2'b00, 16'(c), idx, tag, tgt, tk, vld};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares every table write against the scoreboard
    initial begin
        logic [63:0] act;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mon_en) begin
                act = pack_wr(cyc, tbl_idx, tbl_tag, tbl_target, tbl_taken, tbl_valid);
                if (tbl_we) begin
                    if (expq.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL tbl_write_unexpected at cycle %0d: got %0h expected no write",
                                 cyc, act);
                    end else begin
                        chk("tbl_write", act, expq.pop_front());
                    end
                end else if (expq.size() > 0 && expq[0][61:46] <= 16'(cyc)) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL tbl_write_missing at cycle %0d: got no write expected %0h",
                             cyc, expq[0]);
                    void'(expq.pop_front());
                end
            end
        end
    end

    // One clock of stimulus; called in the low phase, returns at next negedge
    task automatic step(input logic iv, input logic [31:0] ipc, input logic [31:0] itg,
                        input logic itk, input logic bv, input logic [31:0] bpc,
                        input logic [31:0] btg, input logic btk, input logic fl);
        bit     be_pop, if3_pop, merge_ok, x_if3_rdy, x_be_rdy;
        m_ent_t e;
        if3_upd_valid = iv;  if3_upd_pc = ipc; if3_upd_target = itg; if3_upd_taken = itk;
        be_upd_valid  = bv;  be_upd_pc  = bpc; be_upd_target  = btg; be_upd_taken  = btk;
        flush = fl;
        #1;
        be_pop   = mrun && mbe.size() > 0 && !(mif3.size() > 0 && mstarve == SM);
        if3_pop  = mrun && !be_pop && mif3.size() > 0;
        merge_ok = 1'b0;
`ifdef NLP_UPD_MERGE_EN
        if (mrun && mbe.size() > 0 && !(be_pop && mbe.size() == 1))
            merge_ok = (idx_of(mbe[mbe.size()-1].pc) == idx_of(bpc));
`endif
        x_if3_rdy = mrun && (mif3.size() < QD);
        x_be_rdy  = mrun && ((mbe.size() < QD) || merge_ok);
        chk("init_done", 64'(init_done), 64'(mrun));
        chk("if3_upd_ready", 64'(if3_upd_ready), 64'(x_if3_rdy));
        chk("be_upd_ready", 64'(be_upd_ready), 64'(x_be_rdy));

        if (!mrun) begin
            expq.push_back(pack_wr(cyc + 1, IDX_W'(msweep), '0, '0, 1'b0, 1'b0));
            msweep++;
            if (msweep == NENT) mrun = 1'b1;
        end else begin
            if (be_pop) begin
                e = mbe.pop_front();
                expq.push_back(pack_wr(cyc + 1, idx_of(e.pc), tag_of(e.pc), e.target, e.taken, 1'b1));
                mstarve = (mif3.size() > 0) ? ((mstarve < SM) ? mstarve + 1 : SM) : 0;
            end else if (if3_pop) begin
                e = mif3.pop_front();
                expq.push_back(pack_wr(cyc + 1, idx_of(e.pc), tag_of(e.pc), e.target, e.taken, 1'b1));
                mstarve = 0;
            end
            if (bv && x_be_rdy) begin
                e = '{pc: bpc, target: btg, taken: btk};
                if (merge_ok) mbe[mbe.size()-1] = e;
                else          mbe.push_back(e);
            end
            if (fl) begin
                mif3.delete();
                mstarve = 0;
            end else if (iv && x_if3_rdy) begin
                mif3.push_back('{pc: ipc, target: itg, taken: itk});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, '0, '0, 0, 0);
    endtask

    function automatic logic [31:0] rand_pc(input int span);
        logic [31:0] pc;
        pc      = $urandom;
        pc[5:2] = 4'($urandom_range(0, span - 1));
        pc[1:0] = 2'b00;
        return pc;
    endfunction

    task automatic rand_step(input int p_if3, input int p_be, input int p_fl, input int span);
        step(($urandom_range(0, 99) < p_if3), rand_pc(16), $urandom, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 99) < p_be), rand_pc(span), $urandom, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 99) < p_fl));
    endtask

    task automatic reset_model();
        mif3.delete();
        mbe.delete();
        expq.delete();
        mstarve = 0;
        mrun    = 1'b0;
        msweep  = 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_tbl_we", 64'(tbl_we), 64'(0));
        chk("rst_tbl_idx", 64'(tbl_idx), 64'(0));
        chk("rst_init_done", 64'(init_done), 64'(0));
        chk("rst_if3_ready", 64'(if3_upd_ready), 64'(0));
        chk("rst_be_ready", 64'(be_upd_ready), 64'(0));
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; mon_en = 1'b0;
        rst = 1'b1;
        if3_upd_valid = 0; if3_upd_pc = '0; if3_upd_target = '0; if3_upd_taken = 0;
        be_upd_valid  = 0; be_upd_pc  = '0; be_upd_target  = '0; be_upd_taken  = 0;
        flush = 0;
        reset_model();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        mon_en = 1'b1;

        // Invalidate sweep, then settle
        idle(NENT + 2);

        // Single backend update
        step(0, '0, '0, 0, 1, 32'h8000_0010, 32'h8000_0100, 1, 0);
        idle(3);

        // IF3 and backend in the same cycle
        step(1, 32'h8000_0024, 32'h8000_0200, 0, 1, 32'h8000_0038, 32'h8000_0300, 1, 0);
        idle(3);

        // One IF3 entry against a continuous backend stream
        step(1, 32'h0000_1004, 32'h0000_2000, 1, 1, 32'h0000_3008, 32'h0000_4000, 0, 0);
        for (int i = 0; i < 8; i++)
            step(0, '0, '0, 0, 1, 32'h0000_5000 + 32'(i * 4), 32'h0000_6000 + 32'(i), 1, 0);
        idle(4);

        // Three IF3 entries held back by backend traffic, then flush
        for (int i = 0; i < 3; i++)
            step(1, 32'h0001_0000 + 32'(i * 4), 32'h0002_0000 + 32'(i), 1,
                 1, 32'h0003_0000 + 32'(i * 8), 32'h0004_0000 + 32'(i), 0, 0);
        step(0, '0, '0, 0, 1, 32'h0005_0010, 32'h0006_0000, 1, 1);
        idle(8);

        // Randomised phases: sparse, dense, same-index backend, flush-heavy
        for (int i = 0; i < 250; i++) rand_step(30, 30, 0, 16);
        for (int i = 0; i < 250; i++) rand_step(90, 90, 2, 16);
        for (int i = 0; i < 250; i++) rand_step(100, 100, 0, 1);
        for (int i = 0; i < 250; i++) rand_step(50, 100, 5, 2);
        for (int i = 0; i < 250; i++) rand_step(100, 20, 3, 16);
        for (int i = 0; i < 250; i++) rand_step(70, 95, 1, 4);

        // Asynchronous reset with queues populated
        for (int i = 0; i < 6; i++) rand_step(100, 100, 0, 16);
        idle(0);
        if3_upd_valid = 0; be_upd_valid = 0; flush = 0;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        idle(NENT + 2);
        for (int i = 0; i < 60; i++) rand_step(60, 60, 2, 8);
        idle(12);

        chk("writes_outstanding", 64'(expq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
